// File: rtl/local_inject_queue_pkg.sv
// -----------------------------------------------------------------------------
// local_inject_queue_pkg
// Shared definitions for the PE injection queue.
//   - Global router defines: `WIDTH_COORDINATE, `CURRENT_POS_X, `CURRENT_POS_Y,
//     `NUM_PORT. Each has a default here unless the build already defines it.
//   - Default flit field offsets for the destination coordinates.
//   - Helper that tests whether a destination is this router's own tile.
// Optional build macro used by the top level: INJ_LOCAL_LOOPBACK_EN.
// -----------------------------------------------------------------------------
`ifndef WIDTH_COORDINATE
`define WIDTH_COORDINATE 4
`endif
`ifndef CURRENT_POS_X
`define CURRENT_POS_X 1
`endif
`ifndef CURRENT_POS_Y
`define CURRENT_POS_Y 1
`endif
`ifndef NUM_PORT
`define NUM_PORT 5
`endif

package local_inject_queue_pkg;

    localparam int COORD_W        = `WIDTH_COORDINATE;
    localparam int CUR_POS_X      = `CURRENT_POS_X;
    localparam int CUR_POS_Y      = `CURRENT_POS_Y;
    localparam int NUM_PORT       = `NUM_PORT;

    // Destination X sits in the lowest bits, Y directly above it.
    localparam int FLIT_DST_X_LSB = 0;
    localparam int FLIT_DST_Y_LSB = `WIDTH_COORDINATE;

    // True when the given destination is the tile this router serves.
    function automatic logic is_local_dst(input logic [COORD_W-1:0] dst_x,
                                          input logic [COORD_W-1:0] dst_y);
        return (dst_x == COORD_W'(CUR_POS_X)) && (dst_y == COORD_W'(CUR_POS_Y));
    endfunction

endpackage

// File: rtl/local_inject_queue_fifo_core.sv
// -----------------------------------------------------------------------------
// inj_fifo_core
// Circular-buffer FIFO storage for the injection queue: array, read/write
// pointers, occupancy counter, full/empty flags.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i          write wr_data_i at the tail (ignored while full)
//   pop_i           drop the head entry (ignored while empty)
//   wr_data_i       data to enqueue
//   rd_data_o       head entry, zero while empty
//   full_o/empty_o  status flags
//   occupancy_o     number of valid entries
// A full queue refuses a push even when a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module inj_fifo_core #(
    parameter int FLIT_W = 32,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [FLIT_W-1:0] wr_data_i,
    output logic [FLIT_W-1:0] rd_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [OCC_W-1:0]  occupancy_o
);

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_d;
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_d;
    logic              push_en_s;
    logic              pop_en_s;

    assign full_o      = (occ_q == OCC_W'(DEPTH));
    assign empty_o     = (occ_q == OCC_W'(0));
    assign occupancy_o = occ_q;

    // Qualify requests with the status flags; no pass-through when full.
    assign push_en_s = push_i && !full_o;
    assign pop_en_s  = pop_i && !empty_o;

    // Next-state for pointers and occupancy; DEPTH is a power of two so the
    // pointer increment wraps from DEPTH-1 to 0 on its own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_en_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_en_s, pop_en_s})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (push_en_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Head read, forced to zero while empty so stale data never leaks out.
    always_comb begin
        rd_data_o = '0;
        if (empty_o) begin
            rd_data_o = '0;
        end else begin
            rd_data_o = mem_q[rd_ptr_q];
        end
    end

endmodule

// File: rtl/local_inject_queue.sv
// -----------------------------------------------------------------------------
// local_inject_queue
// Injection-side FIFO between the processing element and the router's Local
// input. The head flit is offered to the router whenever it reports a free
// input slot; an asserted inj_valid commits the pop (bufferless router, no
// backpressure after injection). The head destination is exposed to Local-port
// route computation, and a counter flags head-of-line starvation.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   pe_valid/pe_ready      PE push handshake (pe_ready = not full)
//   pe_flit                flit from the PE
//   slot_free              router has an empty input slot this cycle
//   inj_valid/inj_flit     head injection (combinational)
//   head_dst_x/head_dst_y  head destination coordinates
//   occupancy              number of queued flits
//   starve                 head blocked for STARVE_THRESH consecutive cycles
//   loop_valid/loop_flit   local loopback delivery
// Build macro: INJ_LOCAL_LOOPBACK_EN -- when defined, a head flit addressed to
// this tile bypasses the network on loop_valid/loop_flit; otherwise those
// outputs are tied to zero and such flits are injected normally.
// -----------------------------------------------------------------------------
module local_inject_queue
    import local_inject_queue_pkg::*;
#(
    parameter int FLIT_W        = 32,
    parameter int DEPTH         = 4,
    parameter int DST_X_LSB     = FLIT_DST_X_LSB,
    parameter int DST_Y_LSB     = FLIT_DST_Y_LSB,
    parameter int STARVE_THRESH = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pe_valid,
    output logic                     pe_ready,
    input  logic [FLIT_W-1:0]        pe_flit,
    input  logic                     slot_free,
    output logic                     inj_valid,
    output logic [FLIT_W-1:0]        inj_flit,
    output logic [COORD_W-1:0]       head_dst_x,
    output logic [COORD_W-1:0]       head_dst_y,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     starve,
    output logic                     loop_valid,
    output logic [FLIT_W-1:0]        loop_flit
);

    localparam int CNT_W = $clog2(STARVE_THRESH + 1);

    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [FLIT_W-1:0] head_flit_s;
    logic              head_pop_s;
    logic              inj_valid_s;
    logic              loop_valid_s;
    logic [CNT_W-1:0]  starve_cnt_q;
    logic [CNT_W-1:0]  starve_cnt_d;
    logic              starve_q;

    inj_fifo_core #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .push_i      (pe_valid),
        .pop_i       (head_pop_s),
        .wr_data_i   (pe_flit),
        .rd_data_o   (head_flit_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .occupancy_o (occupancy)
    );

    assign pe_ready   = !fifo_full_s;
    assign inj_flit   = head_flit_s;
    assign head_dst_x = head_flit_s[DST_X_LSB +: COORD_W];
    assign head_dst_y = head_flit_s[DST_Y_LSB +: COORD_W];

`ifdef INJ_LOCAL_LOOPBACK_EN
    // A head addressed to this tile leaves via loopback, independent of
    // slot_free, and is never offered to the network.
    assign loop_valid_s = !fifo_empty_s && is_local_dst(head_dst_x, head_dst_y);
    assign loop_flit    = loop_valid_s ? head_flit_s : '0;
`else
    assign loop_valid_s = 1'b0;
    assign loop_flit    = '0;
`endif

    assign inj_valid_s = !fifo_empty_s && slot_free && !loop_valid_s;
    assign head_pop_s  = inj_valid_s || loop_valid_s;
    assign inj_valid   = inj_valid_s;
    assign loop_valid  = loop_valid_s;
    assign starve      = starve_q;

    // Count consecutive cycles the head stays queued; any departure or an
    // empty queue restarts the count, and it saturates at the threshold.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (fifo_empty_s || head_pop_s) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != CNT_W'(STARVE_THRESH)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Starve counter and its registered flag, kept cycle-aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            starve_q     <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            starve_q     <= (starve_cnt_d == CNT_W'(STARVE_THRESH));
        end
    end

endmodule

// File: tb/tb_local_inject_queue.sv
// -----------------------------------------------------------------------------
// tb_local_inject_queue
// Directed bench for local_inject_queue: a vector table for fill / drain in
// FIFO order, then hand-written sequences for starvation, latency, reset in
// mid-stream and local-destination handling (both builds of
// INJ_LOCAL_LOOPBACK_EN).
// -----------------------------------------------------------------------------
module tb_local_inject_queue;
    import local_inject_queue_pkg::*;

    localparam int FLIT_W = 32;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst_n;
    logic              pe_valid;
    logic              pe_ready;
    logic [FLIT_W-1:0] pe_flit;
    logic              slot_free;
    logic              inj_valid;
    logic [FLIT_W-1:0] inj_flit;
    logic [COORD_W-1:0] head_dst_x;
    logic [COORD_W-1:0] head_dst_y;
    logic [2:0]        occupancy;
    logic              starve;
    logic              loop_valid;
    logic [FLIT_W-1:0] loop_flit;

    int errors = 0;
    int checks = 0;

    local_inject_queue #(
        .FLIT_W        (FLIT_W),
        .DEPTH         (DEPTH),
        .STARVE_THRESH (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pe_valid   (pe_valid),
        .pe_ready   (pe_ready),
        .pe_flit    (pe_flit),
        .slot_free  (slot_free),
        .inj_valid  (inj_valid),
        .inj_flit   (inj_flit),
        .head_dst_x (head_dst_x),
        .head_dst_y (head_dst_y),
        .occupancy  (occupancy),
        .starve     (starve),
        .loop_valid (loop_valid),
        .loop_flit  (loop_flit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [31:0] flit;
        logic        sf;
        logic        rdy;
        logic        iv;
        logic [31:0] hf;
        logic [2:0]  occ;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [31:0] mk(input int dx, input int dy, input int tag);
        logic [31:0] f;
        f = {tag[23:0], dy[3:0], dx[3:0]};
        return f;
    endfunction

    function automatic vec_t mv(input logic pv, input logic [31:0] fl, input logic sf,
                                input logic rdy, input logic iv, input logic [31:0] hf,
                                input logic [2:0] occ);
        vec_t v;
        v.pv = pv; v.flit = fl; v.sf = sf; v.rdy = rdy; v.iv = iv; v.hf = hf; v.occ = occ;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock: commit at posedge, then move off the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check head-related outputs against an expected head flit.
    task automatic chk_head(input string name, input logic [31:0] hf);
        logic [3:0] ex;
        logic [3:0] ey;
        ex = hf[3:0];
        ey = hf[7:4];
        chk({name, ".inj_flit"}, 64'(inj_flit), 64'(hf));
        chk({name, ".dst_x"}, 64'(head_dst_x), 64'(ex));
        chk({name, ".dst_y"}, 64'(head_dst_y), 64'(ey));
    endtask

    logic [31:0] f1, f2, f3, f4, f5, f6, f7, fs, fl, fr, fo;

    initial begin
        f1 = mk(2, 3, 1);  f2 = mk(3, 0, 2);  f3 = mk(0, 2, 3);  f4 = mk(7, 5, 4);
        f5 = mk(4, 4, 5);  f6 = mk(9, 8, 6);  f7 = mk(15, 14, 7);
        fs = mk(2, 3, 8);  fl = mk(5, 6, 9);  fr = mk(6, 2, 10);
        fo = mk(CUR_POS_X, CUR_POS_Y, 11);

        //               pv    flit   sf    rdy   iv    head   occ
        vecs[0]  = mv(1'b1, f1,  1'b0, 1'b1, 1'b0, 32'h0, 3'd0);
        vecs[1]  = mv(1'b1, f2,  1'b0, 1'b1, 1'b0, f1,    3'd1);
        vecs[2]  = mv(1'b1, f3,  1'b0, 1'b1, 1'b0, f1,    3'd2);
        vecs[3]  = mv(1'b1, f4,  1'b0, 1'b1, 1'b0, f1,    3'd3);
        vecs[4]  = mv(1'b1, f5,  1'b0, 1'b0, 1'b0, f1,    3'd4); // 5th rejected
        vecs[5]  = mv(1'b1, f5,  1'b1, 1'b0, 1'b1, f1,    3'd4); // pop only
        vecs[6]  = mv(1'b1, f5,  1'b1, 1'b1, 1'b1, f2,    3'd3); // push+pop
        vecs[7]  = mv(1'b1, f6,  1'b1, 1'b1, 1'b1, f3,    3'd3);
        vecs[8]  = mv(1'b1, f7,  1'b1, 1'b1, 1'b1, f4,    3'd3);
        vecs[9]  = mv(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, f5,  3'd3);
        vecs[10] = mv(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, f6,  3'd2);
        vecs[11] = mv(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, f7,  3'd1);
        vecs[12] = mv(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0);

        // Reset state
        rst_n = 1'b0; pe_valid = 1'b0; pe_flit = '0; slot_free = 1'b1;
        #2;
        chk("rst.pe_ready", 64'(pe_ready), 64'd1);
        chk("rst.inj_valid", 64'(inj_valid), 64'd0);
        chk("rst.occupancy", 64'(occupancy), 64'd0);
        chk("rst.starve", 64'(starve), 64'd0);
        chk("rst.loop_valid", 64'(loop_valid), 64'd0);
        chk_head("rst", 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Table: fill to full, reject 5th, drain in FIFO order
        for (int i = 0; i < 13; i++) begin
            pe_valid = vecs[i].pv; pe_flit = vecs[i].flit; slot_free = vecs[i].sf;
            @(negedge clk);
            chk($sformatf("vec%0d.pe_ready", i), 64'(pe_ready), 64'(vecs[i].rdy));
            chk($sformatf("vec%0d.inj_valid", i), 64'(inj_valid), 64'(vecs[i].iv));
            chk($sformatf("vec%0d.occupancy", i), 64'(occupancy), 64'(vecs[i].occ));
            chk_head($sformatf("vec%0d", i), vecs[i].hf);
            chk($sformatf("vec%0d.starve", i), 64'(starve), 64'd0);
            tick();
        end

        // Starvation: head dst (2,3) blocked for 20 cycles
        pe_valid = 1'b1; pe_flit = fs; slot_free = 1'b0;
        tick();
        pe_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            chk($sformatf("starve.cyc%0d", c), 64'(starve), 64'(c >= 16));
            chk($sformatf("starve.cyc%0d.inj_valid", c), 64'(inj_valid), 64'd0);
            tick();
        end
        slot_free = 1'b1;
        @(negedge clk);
        chk("starve.release.inj_valid", 64'(inj_valid), 64'd1);
        chk_head("starve.release", fs);
        tick();
        slot_free = 1'b0;
        @(negedge clk);
        chk("starve.after.starve", 64'(starve), 64'd0);
        chk("starve.after.occupancy", 64'(occupancy), 64'd0);
        tick();

        // Latency: push in cycle N, inject in N+1
        pe_valid = 1'b1; pe_flit = fl; slot_free = 1'b1;
        @(negedge clk);
        chk("lat.N.inj_valid", 64'(inj_valid), 64'd0);
        tick();
        pe_valid = 1'b0;
        @(negedge clk);
        chk("lat.N1.inj_valid", 64'(inj_valid), 64'd1);
        chk_head("lat.N1", fl);
        tick();

        // Reset mid-stream with three flits queued and starve set
        slot_free = 1'b0; pe_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pe_flit = mk(3 + k, 2, 20 + k);
            tick();
        end
        pe_valid = 1'b0;
        for (int k = 0; k < 16; k++) tick();
        @(negedge clk);
        chk("midrst.pre.occupancy", 64'(occupancy), 64'd3);
        chk("midrst.pre.starve", 64'(starve), 64'd1);
        #2;
        slot_free = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst.occupancy", 64'(occupancy), 64'd0);
        chk("midrst.inj_valid", 64'(inj_valid), 64'd0);
        chk("midrst.starve", 64'(starve), 64'd0);
        chk("midrst.pe_ready", 64'(pe_ready), 64'd1);
        chk_head("midrst", 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        pe_valid = 1'b1; pe_flit = fr; slot_free = 1'b1;
        @(negedge clk);
        chk("postrst.inj_valid", 64'(inj_valid), 64'd0);
        tick();
        pe_valid = 1'b0;
        @(negedge clk);
        chk("postrst.inj_valid1", 64'(inj_valid), 64'd1);
        chk("postrst.occupancy", 64'(occupancy), 64'd1);
        chk_head("postrst", fr);
        tick();

        // Head addressed to this tile, slot_free held low
        pe_valid = 1'b1; pe_flit = fo; slot_free = 1'b0;
        tick();
        pe_valid = 1'b0;
        @(negedge clk);
        chk("local.inj_valid", 64'(inj_valid), 64'd0);
`ifdef INJ_LOCAL_LOOPBACK_EN
        chk("local.loop_valid", 64'(loop_valid), 64'd1);
        chk("local.loop_flit", 64'(loop_flit), 64'(fo));
        tick();
        @(negedge clk);
        chk("local.after.occupancy", 64'(occupancy), 64'd0);
        chk("local.after.loop_valid", 64'(loop_valid), 64'd0);
        chk("local.after.starve", 64'(starve), 64'd0);
`else
        chk("local.loop_valid", 64'(loop_valid), 64'd0);
        chk("local.loop_flit", 64'(loop_flit), 64'd0);
        tick();
        @(negedge clk);
        chk("local.held.occupancy", 64'(occupancy), 64'd1);
        chk("local.held.inj_valid", 64'(inj_valid), 64'd0);
        tick();
        slot_free = 1'b1;
        @(negedge clk);
        chk("local.inject.inj_valid", 64'(inj_valid), 64'd1);
        chk_head("local.inject", fo);
        tick();
        @(negedge clk);
        chk("local.after.occupancy", 64'(occupancy), 64'd0);
`endif
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
